s_msg_buffer: RTL and testbench

- Parametrised, frame-aware message buffer between the SPI slave byte engine (s_spi_control) and the system.
- Captures received bytes into an RX memory and tracks frame length via slave-select edges.
- Supplies the next TX byte from a host-writable TX memory.
- Exposes a registered random-access read port for the display path.

---
 rtl/s_spi_pkg.sv | 14 +
 rtl/s_edge_det.sv | 26 ++
 rtl/s_msg_buffer.sv | 149 ++++++++++++++
 tb/tb_s_msg_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_spi_pkg.sv
// Shared defaults for the SPI slave message path: data width, fill/blank bytes and the
// index-width helper used to size memory addresses.
package s_spi_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam logic [7:0]  TX_FILL_DEF  = 8'h00;
  localparam logic [7:0]  RD_BLANK_DEF = 8'h20;

  // A depth of 1 would give a zero-width index, so clamp to at least one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/s_edge_det.sv
// Registers a synchronous input and flags its rising and falling edges against the
// one-cycle-delayed copy; the delayed copy resets to RESET_VAL.
module s_edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= RESET_VAL;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = ~sig_q & sig;
  assign fall = sig_q & ~sig;

endmodule

// File: rtl/s_msg_buffer.sv
// Frame-aware RX/TX message buffer between the SPI slave byte engine and the system.
// Optional build macro RX_CHECKSUM_EN adds the rx_csum output (XOR of stored frame bytes).
module s_msg_buffer
  import s_spi_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       ADDR_W   = addr_w(DEPTH),
  parameter bit                OVF_WRAP = 1'b0,
  parameter logic [DATA_W-1:0] TX_FILL  = DATA_W'(TX_FILL_DEF),
  parameter logic [DATA_W-1:0] RD_BLANK = DATA_W'(RD_BLANK_DEF)
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              ss,
  input  logic              rx_busy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr_en,
  input  logic [ADDR_W-1:0] tx_wr_addr,
  input  logic [DATA_W-1:0] tx_wr_data,
  input  logic [ADDR_W:0]   tx_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   rx_len,
  output logic              frame_done,
  output logic              overflow
`ifdef RX_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] rx_csum
`endif
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [DATA_W-1:0] tx_mem [DEPTH];

  logic              frame_start, frame_end, rx_cap, tx_adv;
  logic              rx_busy_rise, tx_busy_rise;
  logic              rx_full, rx_store;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   tx_idx;
  logic              unused_edges;

  s_edge_det #(.RESET_VAL(1'b1)) u_ss_edge (
    .clk  (clk),
    .rst  (rst_btn),
    .sig  (ss),
    .rise (frame_end),
    .fall (frame_start)
  );

  s_edge_det #(.RESET_VAL(1'b0)) u_rx_edge (
    .clk  (clk),
    .rst  (rst_btn),
    .sig  (rx_busy),
    .rise (rx_busy_rise),
    .fall (rx_cap)
  );

  s_edge_det #(.RESET_VAL(1'b0)) u_tx_edge (
    .clk  (clk),
    .rst  (rst_btn),
    .sig  (tx_busy),
    .rise (tx_busy_rise),
    .fall (tx_adv)
  );

  assign unused_edges = rx_busy_rise ^ tx_busy_rise;

  // A byte landing on the frame_start cycle belongs to no frame and is discarded.
  assign rx_full  = (rx_len == FULL);
  assign rx_store = ~rst_btn & rx_cap & ~frame_start & (~rx_full | OVF_WRAP);

  always_ff @(posedge clk) begin
    if (rx_store) begin
      rx_mem[wr_ptr] <= rx_data;
    end
  end

  // wr_ptr tracks rx_len until the memory fills, then keeps rolling for the wrap mode.
  always_ff @(posedge clk) begin
    if (rst_btn) begin
      rx_len     <= '0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_start) begin
        rx_len   <= '0;
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else if (rx_cap) begin
        if (!rx_full) begin
          rx_len <= rx_len + (ADDR_W+1)'(1);
        end else begin
          overflow <= 1'b1;
        end
        if (rx_store) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      rd_data <= '0;
    end else begin
      rd_data <= ({1'b0, rd_addr} < rx_len) ? rx_mem[rd_addr] : RD_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr_en) begin
      tx_mem[tx_wr_addr] <= tx_wr_data;
    end
  end

  // tx_mem reads see pre-write contents when a host write hits the same cycle.
  always_ff @(posedge clk) begin
    if (rst_btn) begin
      tx_idx  <= '0;
      tx_data <= TX_FILL;
    end else if (frame_start) begin
      tx_idx  <= (ADDR_W+1)'(1);
      tx_data <= (tx_len != '0) ? tx_mem[0] : TX_FILL;
    end else if (tx_adv) begin
      tx_data <= (tx_idx < tx_len) ? tx_mem[tx_idx[ADDR_W-1:0]] : TX_FILL;
      if (tx_idx != FULL) begin
        tx_idx <= tx_idx + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef RX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst_btn || frame_start) begin
      rx_csum <= '0;
    end else if (rx_store) begin
      rx_csum <= rx_csum ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_s_msg_buffer.sv
// Directed plus randomized bench for s_msg_buffer: one default instance and two DEPTH=4
// instances (drop and wrap overflow) share the engine-side stimulus.
module tb_s_msg_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_btn, ss, rx_busy, tx_busy, tx_wr_en;
  logic [7:0] rx_data, tx_wr_data;
  logic [5:0] tx_wr_addr, rd_addr;
  logic [6:0] tx_len;
  logic [1:0] rd_addr_s;

  logic [7:0] tx_data0, tx_data1, tx_data2, rd_data0, rd_data1, rd_data2;
  logic [6:0] rx_len0;
  logic [2:0] rx_len1, rx_len2;
  logic       frame_done0, frame_done1, frame_done2;
  logic       overflow0, overflow1, overflow2;
`ifdef RX_CHECKSUM_EN
  logic [7:0] csum0, csum1, csum2;
`endif

  s_msg_buffer #(.DEPTH(64)) u_dut0 (
    .clk(clk), .rst_btn(rst_btn), .ss(ss), .rx_busy(rx_busy), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data0), .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr),
    .tx_wr_data(tx_wr_data), .tx_len(tx_len), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rx_len(rx_len0), .frame_done(frame_done0), .overflow(overflow0)
`ifdef RX_CHECKSUM_EN
    , .rx_csum(csum0)
`endif
  );

  s_msg_buffer #(.DEPTH(4), .OVF_WRAP(1'b0)) u_dut1 (
    .clk(clk), .rst_btn(rst_btn), .ss(ss), .rx_busy(rx_busy), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data1), .tx_wr_en(1'b0), .tx_wr_addr(2'b00),
    .tx_wr_data(8'h00), .tx_len(3'b000), .rd_addr(rd_addr_s), .rd_data(rd_data1),
    .rx_len(rx_len1), .frame_done(frame_done1), .overflow(overflow1)
`ifdef RX_CHECKSUM_EN
    , .rx_csum(csum1)
`endif
  );

  s_msg_buffer #(.DEPTH(4), .OVF_WRAP(1'b1)) u_dut2 (
    .clk(clk), .rst_btn(rst_btn), .ss(ss), .rx_busy(rx_busy), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data2), .tx_wr_en(1'b0), .tx_wr_addr(2'b00),
    .tx_wr_data(8'h00), .tx_len(3'b000), .rd_addr(rd_addr_s), .rd_data(rd_data2),
    .rx_len(rx_len2), .frame_done(frame_done2), .overflow(overflow2)
`ifdef RX_CHECKSUM_EN
    , .rx_csum(csum2)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: bytes of a frame are numbered n = 0,1,2...; byte n lives at address n
  // while n < depth, at n mod depth in wrap mode, and is lost otherwise.
  int         depth_m [3] = '{64, 4, 4};
  bit         wrap_m  [3] = '{1'b0, 1'b0, 1'b1};
  int         nrx     [3];
  logic [7:0] mref    [3][64];
  logic [7:0] csum_m  [3];
  logic [7:0] msg     [64];
  int         txl;
  logic [7:0] fbytes  [16];

  function automatic void model_start();
    for (int d = 0; d < 3; d++) begin
      nrx[d]    = 0;
      csum_m[d] = 8'h00;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    for (int d = 0; d < 3; d++) begin
      if (nrx[d] < depth_m[d]) begin
        mref[d][nrx[d]] = b;
        csum_m[d] ^= b;
      end else if (wrap_m[d]) begin
        mref[d][nrx[d] % depth_m[d]] = b;
        csum_m[d] ^= b;
      end
      nrx[d]++;
    end
  endfunction

  function automatic int exp_len(input int d);
    return (nrx[d] < depth_m[d]) ? nrx[d] : depth_m[d];
  endfunction

  function automatic logic [7:0] exp_rd(input int d, input int a);
    return (a < exp_len(d)) ? mref[d][a] : 8'h20;
  endfunction

  function automatic logic [7:0] exp_tx(input int k);
    return (k < txl) ? msg[k] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic fd);
    chk({tag, "/done0"}, frame_done0, fd);
    chk({tag, "/done1"}, frame_done1, fd);
    chk({tag, "/done2"}, frame_done2, fd);
    chk({tag, "/len0"}, rx_len0, exp_len(0));
    chk({tag, "/len1"}, rx_len1, exp_len(1));
    chk({tag, "/len2"}, rx_len2, exp_len(2));
    chk({tag, "/ovf0"}, overflow0, nrx[0] > depth_m[0]);
    chk({tag, "/ovf1"}, overflow1, nrx[1] > depth_m[1]);
    chk({tag, "/ovf2"}, overflow2, nrx[2] > depth_m[2]);
`ifdef RX_CHECKSUM_EN
    chk({tag, "/csum0"}, csum0, csum_m[0]);
    chk({tag, "/csum1"}, csum1, csum_m[1]);
    chk({tag, "/csum2"}, csum2, csum_m[2]);
`endif
  endtask

  task automatic write_tx(input int a, input logic [7:0] d);
    tx_wr_en   = 1'b1;
    tx_wr_addr = 6'(a);
    tx_wr_data = d;
    tick();
    tx_wr_en   = 1'b0;
    msg[a]     = d;
  endtask

  // One engine byte: busy high for two cycles, both busy lines fall together.
  task automatic xfer(input logic [7:0] b);
    rx_data = b;
    rx_busy = 1'b1;
    tx_busy = 1'b1;
    tick();
    tick();
    rx_busy = 1'b0;
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic read_back(input string tag);
    for (int a = 0; a < 10; a++) begin
      rd_addr   = 6'(a);
      rd_addr_s = 2'(a);
      tick();
      chk({tag, "/rd0"}, rd_data0, exp_rd(0, a));
      if (a < 4) begin
        chk({tag, "/rd1"}, rd_data1, exp_rd(1, a));
        chk({tag, "/rd2"}, rd_data2, exp_rd(2, a));
      end
    end
  endtask

  task automatic do_frame(input string tag, input int nb);
    ss = 1'b0;
    tick();
    model_start();
    check_status({tag, "/start"}, 1'b0);
    for (int k = 0; k < nb; k++) begin
      chk({tag, "/tx"}, tx_data0, exp_tx(k));
      xfer(fbytes[k]);
      model_byte(fbytes[k]);
    end
    chk({tag, "/tx_end"}, tx_data0, exp_tx(nb));
    ss = 1'b1;
    tick();
    check_status({tag, "/end"}, 1'b1);
    tick();
    check_status({tag, "/post"}, 1'b0);
    read_back(tag);
  endtask

  initial begin
    logic [7:0] old0;
    logic [39:0] slave;

    rst_btn = 1'b1; ss = 1'b1; rx_busy = 1'b0; tx_busy = 1'b0; rx_data = 8'h00;
    tx_wr_en = 1'b0; tx_wr_addr = '0; tx_wr_data = 8'h00; tx_len = '0;
    rd_addr = '0; rd_addr_s = '0; txl = 0;
    model_start();
    tick();
    tick();
    chk("rst/tx_data", tx_data0, 8'h00);
    chk("rst/rd_data", rd_data0, 8'h00);
    check_status("rst", 1'b0);
    rst_btn = 1'b0;
    tick();
    chk("idle/rd_blank", rd_data0, 8'h20);

    // Host loads "SLAVE" and a three-byte frame arrives.
    slave = "SLAVE";
    for (int i = 0; i < 5; i++) write_tx(i, slave[39-8*i -: 8]);
    txl = 5;
    tx_len = 7'd5;
    fbytes[0] = 8'h41; fbytes[1] = 8'h42; fbytes[2] = 8'h43;
    do_frame("abc", 3);

    // Seven-byte frame: S,L,A,V,E then fill bytes.
    for (int k = 0; k < 7; k++) fbytes[k] = 8'(8'h60 + k);
    do_frame("slave7", 7);
    chk("small/tx_fill", tx_data1, 8'h00);

    // Six bytes into the DEPTH=4 instances: drop vs wrap, then a fresh frame clears overflow.
    for (int k = 0; k < 6; k++) fbytes[k] = 8'(k + 1);
    do_frame("ovf6", 6);
    fbytes[0] = 8'h12; fbytes[1] = 8'h34; fbytes[2] = 8'hFF;
    do_frame("csum", 3);

    // Host write to tx_mem[0] on the frame_start cycle: the frame sees the old byte.
    old0 = msg[0];
    tx_wr_en = 1'b1; tx_wr_addr = 6'd0; tx_wr_data = ~old0; ss = 1'b0;
    tick();
    tx_wr_en = 1'b0;
    model_start();
    chk("wr_collide/tx", tx_data0, old0);
    msg[0] = ~old0;
    ss = 1'b1;
    tick();
    tick();

    // rx_cap and tx_adv on the ss-fall cycle: byte discarded, frame_start wins for TX.
    rx_data = 8'hAA; rx_busy = 1'b1; tx_busy = 1'b1;
    tick();
    tick();
    ss = 1'b0; rx_busy = 1'b0; tx_busy = 1'b0;
    tick();
    model_start();
    check_status("simul_start", 1'b0);
    chk("simul_start/tx", tx_data0, exp_tx(0));
    xfer(8'h5A);
    model_byte(8'h5A);
    chk("simul_start/tx1", tx_data0, exp_tx(1));
    // rx_cap on the ss-rise cycle: byte still counts.
    rx_data = 8'h6B; rx_busy = 1'b1;
    tick();
    tick();
    ss = 1'b1; rx_busy = 1'b0;
    tick();
    model_byte(8'h6B);
    check_status("simul_end", 1'b1);
    tick();
    read_back("simul");

    // Randomized frames with fresh TX contents and lengths.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 8; i++) write_tx(i, 8'($urandom));
      txl = int'($urandom_range(0, 8));
      tx_len = 7'(txl);
      for (int k = 0; k < 10; k++) fbytes[k] = 8'($urandom);
      do_frame("rand", int'($urandom_range(0, 9)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
